// File: rtl/board_io_ctrl.sv
// Board I/O front end: input synchronisers, button debounce with press pulses,
// tri-colour LED PWM and a write-strobed output data register.
// Optional macro BOARD_IO_RELEASE_PULSE_EN adds o_btn_release (1->0 pulses).
module board_io_ctrl #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned NUM_SW          = 4,
  parameter int unsigned NUM_RGB         = 2,
  parameter int unsigned PWM_BITS        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DATA_W          = 16
) (
  input  logic                         i_CLK100MHZ,
  input  logic                         i_RST_N,
  input  logic [NUM_BTN-1:0]           BTN,
  input  logic [NUM_SW-1:0]            SW,
  output logic [NUM_BTN-1:0]           o_btn_level,
  output logic [NUM_BTN-1:0]           o_btn_press,
`ifdef BOARD_IO_RELEASE_PULSE_EN
  output logic [NUM_BTN-1:0]           o_btn_release,
`endif
  output logic [NUM_SW-1:0]            o_sw_level,
  input  logic [NUM_RGB*PWM_BITS-1:0]  i_r_duty,
  input  logic [NUM_RGB*PWM_BITS-1:0]  i_g_duty,
  input  logic [NUM_RGB*PWM_BITS-1:0]  i_b_duty,
  output logic [NUM_RGB-1:0]           RLED,
  output logic [NUM_RGB-1:0]           GLED,
  output logic [NUM_RGB-1:0]           BLED,
  input  logic                         i_data_wr,
  input  logic [DATA_W-1:0]            i_data,
  output logic [DATA_W-1:0]            out_reg_data_out
);

  localparam logic [23:0] DB_MAX = 24'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_sync1_q, btn_sync2_q;
  logic [NUM_SW-1:0]  sw_sync1_q, sw_sync2_q;

  always_ff @(posedge i_CLK100MHZ or negedge i_RST_N) begin
    if (!i_RST_N) begin
      btn_sync1_q <= '0;
      btn_sync2_q <= '0;
      sw_sync1_q  <= '0;
      sw_sync2_q  <= '0;
    end else begin
      btn_sync1_q <= BTN;
      btn_sync2_q <= btn_sync1_q;
      sw_sync1_q  <= SW;
      sw_sync2_q  <= sw_sync1_q;
    end
  end

  assign o_sw_level = sw_sync2_q;

  // ---------------------------------------------------------------------------
  // Debounce and edge pulses
  // ---------------------------------------------------------------------------
  logic [23:0]        btn_cnt_q [NUM_BTN];
  logic [23:0]        btn_cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] btn_level_q, btn_level_d;
  logic [NUM_BTN-1:0] btn_press_q, btn_press_d;
`ifdef BOARD_IO_RELEASE_PULSE_EN
  logic [NUM_BTN-1:0] btn_release_q, btn_release_d;
`endif

  // A single mismatching sample restarts the count: no partial credit survives a bounce.
  always_comb begin
    btn_cnt_d   = btn_cnt_q;
    btn_level_d = btn_level_q;
    btn_press_d = '0;
`ifdef BOARD_IO_RELEASE_PULSE_EN
    btn_release_d = '0;
`endif
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (btn_sync2_q[i] == btn_level_q[i]) begin
        btn_cnt_d[i] = '0;
      end else if (btn_cnt_q[i] == DB_MAX) begin
        btn_cnt_d[i]   = '0;
        btn_level_d[i] = btn_sync2_q[i];
        btn_press_d[i] = btn_sync2_q[i];
`ifdef BOARD_IO_RELEASE_PULSE_EN
        btn_release_d[i] = ~btn_sync2_q[i];
`endif
      end else begin
        btn_cnt_d[i] = btn_cnt_q[i] + 24'd1;
      end
    end
  end

  always_ff @(posedge i_CLK100MHZ or negedge i_RST_N) begin
    if (!i_RST_N) begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        btn_cnt_q[i] <= '0;
      end
      btn_level_q <= '0;
      btn_press_q <= '0;
`ifdef BOARD_IO_RELEASE_PULSE_EN
      btn_release_q <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        btn_cnt_q[i] <= btn_cnt_d[i];
      end
      btn_level_q <= btn_level_d;
      btn_press_q <= btn_press_d;
`ifdef BOARD_IO_RELEASE_PULSE_EN
      btn_release_q <= btn_release_d;
`endif
    end
  end

  assign o_btn_level = btn_level_q;
  assign o_btn_press = btn_press_q;
`ifdef BOARD_IO_RELEASE_PULSE_EN
  assign o_btn_release = btn_release_q;
`endif

  // ---------------------------------------------------------------------------
  // PWM: shared counter, duty shadows reloaded only on the last count of a period
  // ---------------------------------------------------------------------------
  logic [PWM_BITS-1:0]         pwm_cnt_q, pwm_cnt_d;
  logic [NUM_RGB*PWM_BITS-1:0] r_shadow_q, r_shadow_d;
  logic [NUM_RGB*PWM_BITS-1:0] g_shadow_q, g_shadow_d;
  logic [NUM_RGB*PWM_BITS-1:0] b_shadow_q, b_shadow_d;
  logic [NUM_RGB-1:0]          rled_q, rled_d;
  logic [NUM_RGB-1:0]          gled_q, gled_d;
  logic [NUM_RGB-1:0]          bled_q, bled_d;
  logic                        pwm_wrap;

  always_comb begin
    pwm_wrap   = (pwm_cnt_q == '1);
    pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
    r_shadow_d = pwm_wrap ? i_r_duty : r_shadow_q;
    g_shadow_d = pwm_wrap ? i_g_duty : g_shadow_q;
    b_shadow_d = pwm_wrap ? i_b_duty : b_shadow_q;
    rled_d     = '0;
    gled_d     = '0;
    bled_d     = '0;
    for (int unsigned k = 0; k < NUM_RGB; k++) begin
      rled_d[k] = (pwm_cnt_q < r_shadow_q[k*PWM_BITS +: PWM_BITS]);
      gled_d[k] = (pwm_cnt_q < g_shadow_q[k*PWM_BITS +: PWM_BITS]);
      bled_d[k] = (pwm_cnt_q < b_shadow_q[k*PWM_BITS +: PWM_BITS]);
    end
  end

  always_ff @(posedge i_CLK100MHZ or negedge i_RST_N) begin
    if (!i_RST_N) begin
      pwm_cnt_q  <= '0;
      r_shadow_q <= '0;
      g_shadow_q <= '0;
      b_shadow_q <= '0;
      rled_q     <= '0;
      gled_q     <= '0;
      bled_q     <= '0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      r_shadow_q <= r_shadow_d;
      g_shadow_q <= g_shadow_d;
      b_shadow_q <= b_shadow_d;
      rled_q     <= rled_d;
      gled_q     <= gled_d;
      bled_q     <= bled_d;
    end
  end

  assign RLED = rled_q;
  assign GLED = gled_q;
  assign BLED = bled_q;

  // ---------------------------------------------------------------------------
  // Output data register
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    data_d = i_data_wr ? i_data : data_q;
  end

  always_ff @(posedge i_CLK100MHZ or negedge i_RST_N) begin
    if (!i_RST_N) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign out_reg_data_out = data_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl (DEBOUNCE_CYCLES=16, PWM_BITS=4).
module tb_board_io_ctrl;
  localparam int NB = 4;
  localparam int NS = 4;
  localparam int NR = 2;
  localparam int PB = 4;
  localparam int DB = 16;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NB-1:0]    btn = '0;
  logic [NS-1:0]    sw = '0;
  logic [NB-1:0]    btn_level, btn_press;
  logic [NS-1:0]    sw_level;
  logic [NR*PB-1:0] r_duty = '0, g_duty = '0, b_duty = '0;
  logic [NR-1:0]    rled, gled, bled;
  logic             data_wr = 1'b0;
  logic [DW-1:0]    data = '0;
  logic [DW-1:0]    data_out;
`ifdef BOARD_IO_RELEASE_PULSE_EN
  logic [NB-1:0]    btn_release;
`endif

  always #5 clk = ~clk;

  board_io_ctrl #(
    .NUM_BTN(NB), .NUM_SW(NS), .NUM_RGB(NR), .PWM_BITS(PB),
    .DEBOUNCE_CYCLES(DB), .DATA_W(DW)
  ) dut (
    .i_CLK100MHZ(clk), .i_RST_N(rst_n), .BTN(btn), .SW(sw),
    .o_btn_level(btn_level), .o_btn_press(btn_press),
`ifdef BOARD_IO_RELEASE_PULSE_EN
    .o_btn_release(btn_release),
`endif
    .o_sw_level(sw_level),
    .i_r_duty(r_duty), .i_g_duty(g_duty), .i_b_duty(b_duty),
    .RLED(rled), .GLED(gled), .BLED(bled),
    .i_data_wr(data_wr), .i_data(data), .out_reg_data_out(data_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: pin history since reset, window-based debounce.
  logic [NB-1:0] pin_q[$];
  int unsigned   ncyc;
  logic [NB-1:0] m_level, m_press, m_release;
  logic [NS-1:0] m_sw, m_sw_prev;
  logic [PB-1:0] m_duty [3][NR];
  logic [NR-1:0] m_led [3];
  logic [DW-1:0] m_data;

  typedef struct {
    logic          wr;
    logic [DW-1:0] din;
    logic [DW-1:0] exp;
  } dreg_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic pin_at(input int e, input int b);
    if (e < 1) return 1'b0;
    return pin_q[e-1][b];
  endfunction

  function automatic logic [PB-1:0] duty_in(input int c, input int k);
    logic [NR*PB-1:0] v;
    v = (c == 0) ? r_duty : (c == 1) ? g_duty : b_duty;
    return v[k*PB +: PB];
  endfunction

  task automatic model_reset();
    pin_q.delete();
    ncyc = 0;
    m_level = '0; m_press = '0; m_release = '0;
    m_sw = '0; m_sw_prev = '0;
    m_data = '0;
    for (int c = 0; c < 3; c++) begin
      m_led[c] = '0;
      for (int k = 0; k < NR; k++) m_duty[c][k] = '0;
    end
  endtask

  // Called just after each active edge while out of reset, with the inputs seen by that edge.
  task automatic model_step();
    int phase;
    logic flip;
    pin_q.push_back(btn);
    ncyc++;
    m_press = '0;
    m_release = '0;
    for (int b = 0; b < NB; b++) begin
      // Synced sample at edge n is the pin at edge n-2; accept after DB opposite samples.
      flip = 1'b1;
      for (int j = 0; j < DB; j++)
        if (pin_at(int'(ncyc) - 2 - j, b) == m_level[b]) flip = 1'b0;
      if (flip) begin
        m_level[b]   = ~m_level[b];
        m_press[b]   = m_level[b];
        m_release[b] = ~m_level[b];
      end
    end
    m_sw = m_sw_prev;
    m_sw_prev = sw;
    phase = int'((ncyc - 1) % 16);
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < NR; k++) begin
        m_led[c][k] = (phase < int'(m_duty[c][k]));
        if (phase == 15) m_duty[c][k] = duty_in(c, k);
      end
    if (data_wr) m_data = data;
  endtask

  task automatic check_all();
    chk("btn_level", 32'(btn_level), 32'(m_level));
    chk("btn_press", 32'(btn_press), 32'(m_press));
`ifdef BOARD_IO_RELEASE_PULSE_EN
    chk("btn_release", 32'(btn_release), 32'(m_release));
`endif
    chk("sw_level", 32'(sw_level), 32'(m_sw));
    chk("rled", 32'(rled), 32'(m_led[0]));
    chk("gled", 32'(gled), 32'(m_led[1]));
    chk("bled", 32'(bled), 32'(m_led[2]));
    chk("data_out", 32'(data_out), 32'(m_data));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_btn_level", 32'(btn_level), 32'd0);
    chk("rst_btn_press", 32'(btn_press), 32'd0);
    chk("rst_sw_level", 32'(sw_level), 32'd0);
    chk("rst_leds", 32'({rled, gled, bled}), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    dreg_vec_t dvec[8];
    int lat, presses, rels, hi, early;

    dvec[0] = '{1'b1, 16'hA5C3, 16'hA5C3};
    dvec[1] = '{1'b0, 16'hFFFF, 16'hA5C3};
    dvec[2] = '{1'b0, 16'h0000, 16'hA5C3};
    dvec[3] = '{1'b1, 16'h1234, 16'h1234};
    dvec[4] = '{1'b1, 16'h0000, 16'h0000};
    dvec[5] = '{1'b0, 16'hBEEF, 16'h0000};
    dvec[6] = '{1'b1, 16'hFFFF, 16'hFFFF};
    dvec[7] = '{1'b0, 16'h5A5A, 16'hFFFF};

    @(negedge clk);
    do_reset();

    // Reset then idle: switches visible exactly 2 clocks later.
    btn = 4'b0000;
    sw  = 4'b1010;
    tick();
    chk("sw_lat1", 32'(sw_level), 32'd0);
    tick();
    chk("sw_lat2", 32'(sw_level), 32'hA);

    // Clean press and release on BTN[0].
    btn[0] = 1'b1;
    lat = 0; presses = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (btn_press[0] === 1'b1) presses++;
      if (btn_level[0] === 1'b1 && lat == 0) lat = t;
    end
    chk("press_latency", 32'(lat), 32'd18);
    chk("press_pulses", 32'(presses), 32'd1);
    btn[0] = 1'b0;
    lat = 0; presses = 0; rels = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (btn_press[0] === 1'b1) presses++;
`ifdef BOARD_IO_RELEASE_PULSE_EN
      if (btn_release[0] === 1'b1) rels++;
`endif
      if (btn_level[0] === 1'b0 && lat == 0) lat = t;
    end
    chk("release_latency", 32'(lat), 32'd18);
    chk("release_no_press", 32'(presses), 32'd0);
`ifdef BOARD_IO_RELEASE_PULSE_EN
    chk("release_pulses", 32'(rels), 32'd1);
`endif

    // Bounce on BTN[1]: 10 high, 3 low, then held high.
    early = 0;
    btn[1] = 1'b1;
    repeat (10) begin tick(); if (btn_level[1] !== 1'b0) early++; end
    btn[1] = 1'b0;
    repeat (3) begin tick(); if (btn_level[1] !== 1'b0) early++; end
    chk("bounce_no_accept", 32'(early), 32'd0);
    btn[1] = 1'b1;
    lat = 0; presses = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (btn_press[1] === 1'b1) presses++;
      if (btn_level[1] === 1'b1 && lat == 0) lat = t;
    end
    chk("bounce_latency", 32'(lat), 32'd18);
    chk("bounce_pulses", 32'(presses), 32'd1);

    // PWM duty 5, 0, 15 on RLED[0]: steady state, any 16 consecutive cycles.
    r_duty[3:0] = 4'd5;
    repeat (32) tick();
    hi = 0; repeat (16) begin tick(); if (rled[0] === 1'b1) hi++; end
    chk("pwm_duty5", 32'(hi), 32'd5);
    r_duty[3:0] = 4'd0;
    repeat (32) tick();
    hi = 0; repeat (16) begin tick(); if (rled[0] === 1'b1) hi++; end
    chk("pwm_duty0", 32'(hi), 32'd0);
    r_duty[3:0] = 4'd15;
    repeat (32) tick();
    hi = 0; repeat (16) begin tick(); if (rled[0] === 1'b1) hi++; end
    chk("pwm_duty15", 32'(hi), 32'd15);

    // Mid-period duty change 5 -> 12.
    r_duty[3:0] = 4'd5;
    repeat (32) tick();
    while (ncyc % 16 != 0) tick();
    hi = 0;
    repeat (8) begin tick(); if (rled[0] === 1'b1) hi++; end
    r_duty[3:0] = 4'd12;
    repeat (8) begin tick(); if (rled[0] === 1'b1) hi++; end
    chk("pwm_midchange_cur", 32'(hi), 32'd5);
    hi = 0; repeat (16) begin tick(); if (rled[0] === 1'b1) hi++; end
    chk("pwm_midchange_next", 32'(hi), 32'd12);

    // Output register vectors.
    for (int v = 0; v < 8; v++) begin
      data_wr = dvec[v].wr;
      data    = dvec[v].din;
      tick();
      chk("dreg_vec", 32'(data_out), 32'(dvec[v].exp));
    end
    data_wr = 1'b0;

    // Async reset in the middle of a BTN[2] debounce, LEDs driven.
    r_duty = '1; g_duty = '1; b_duty = '1;
    repeat (32) tick();
    btn[2] = 1'b1;
    repeat (10) tick();
    do_reset();
    lat = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (btn_level[2] === 1'b1 && lat == 0) lat = t;
    end
    chk("post_reset_latency", 32'(lat), 32'd18);

    // Randomised run against the model.
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 19) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 7) == 0) sw = NS'($urandom);
      if ($urandom_range(0, 39) == 0) r_duty = (NR*PB)'($urandom);
      if ($urandom_range(0, 39) == 0) g_duty = (NR*PB)'($urandom);
      if ($urandom_range(0, 39) == 0) b_duty = (NR*PB)'($urandom);
      data_wr = ($urandom_range(0, 3) == 0);
      data    = DW'($urandom);
      if (c == 1000) do_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
